// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, transmitter/receiver state
// encoding and the baud divisor calculation used by uart_rx/uart_tx.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clock cycles per serial bit; truncating division, caller keeps it >= 2.
    function automatic int clks_per_bit(input int system_clock, input int baud_rate);
        return system_clock / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-in / serial-out bundle of the buffered UART transmitter.
// The master side supplies valid/data strobes, the slave side is the
// transmitter that drives the line and its status flags.
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic                 din_valid;
    logic [DATA_BITS-1:0] din;
    logic                 dout;
    logic                 full;
    logic                 busy;
    logic                 overflow;

    modport master (
        output din_valid,
        output din,
        input  dout,
        input  full,
        input  busy,
        input  overflow
    );

    modport slave (
        input  din_valid,
        input  din,
        output dout,
        output full,
        output busy,
        output overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO. rdata presents the oldest
// entry whenever empty is low; full and empty are registered flags.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [CNT_W-1:0] w_count_next;

    // Qualify requests against the current flags and work out the next occupancy.
    always_comb begin
        w_do_push    = push & ~r_full;
        w_do_pop     = pop & ~r_empty;
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Pointers wrap naturally at DEPTH; flags are registered from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes arrive as single-cycle valid
// pulses, queue in a small FIFO and are serialised LSB first. Frames
// leave back to back with no idle gap while the FIFO holds data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600,
    parameter int FIFO_DEPTH   = 16
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(SYSTEM_CLOCK, BAUD_RATE);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          r_state;
    logic                 r_dout;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_overflow;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_rdata;
    logic                 w_last_clk;
    logic                 w_pop;

    // Byte queue; a write while full is dropped even if a pop happens on the same edge.
    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.din_valid),
        .pop   (w_pop),
        .wdata (bus.din),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_last_clk = (r_clk_cnt == CNT_LAST);

    // A byte leaves the FIFO when idle, or at the last stop-bit cycle for a gapless follow-on frame.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_last_clk));

    // Frame sequencer: start bit, eight data bits LSB first, stop bit, all with registered line output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_dout    <= 1'b1;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dout <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_shift   <= w_fifo_rdata;
                        r_dout    <= 1'b0;
                        r_clk_cnt <= '0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_last_clk) begin
                        r_clk_cnt <= '0;
                        r_dout    <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_last_clk) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == IDX_LAST) begin
                            r_dout  <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_dout    <= r_shift[1];
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_last_clk) begin
                        r_clk_cnt <= '0;
                        if (!w_fifo_empty) begin
                            r_shift <= w_fifo_rdata;
                            r_dout  <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_dout  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_dout  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // One-cycle flag for a write that arrived while the queue was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= bus.din_valid & w_fifo_full;
        end
    end

    assign bus.dout     = r_dout;
    assign bus.full     = w_fifo_full;
    assign bus.overflow = r_overflow;
    assign bus.busy     = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for the buffered UART transmitter at 16 clocks per bit
// with a 4-entry queue. A line decoder turns dout back into bytes so the
// main sequence can compare against hand-computed byte streams.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int SYS_CLK = 160000;
    localparam int BAUD    = 10000;
    localparam int DEPTH   = 4;
    localparam int CPB     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycle         = 0;
    int overflowCount = 0;
    int readIdx       = 0;

    logic [7:0] rxQueue[$];
    int         rxStart[$];

    uart_tx_fifo_if bus();

    uart_tx_fifo #(
        .SYSTEM_CLOCK (SYS_CLK),
        .BAUD_RATE    (BAUD),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock period; cycle numbers advance on every rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Every comparison funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write strobe; din is scrambled afterwards to show it is ignored.
    task automatic applyStimulus(input logic [7:0] value);
        bus.din_valid = 1'b1;
        bus.din       = value;
        nextCycle();
        bus.din_valid = 1'b0;
        bus.din       = 8'($urandom);
    endtask

    // Bounded wait for the transmitter to drain; running out counts as a failed comparison.
    task automatic waitIdle(input string tag, input int limit);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            nextCycle();
            n++;
        end
        checkOutput(tag, 32'(n < limit), 32'd1);
    endtask

    // Compare the next decoded byte against the expected one; a missing byte reads as 0x100.
    task automatic expectRx(input string tag, input logic [7:0] value);
        logic [31:0] got;
        got = (readIdx < rxQueue.size()) ? 32'(rxQueue[readIdx]) : 32'h100;
        checkOutput(tag, got, 32'(value));
        readIdx++;
    endtask

    // Cycles between the start bits of two consecutive decoded frames, -1 if unavailable.
    function automatic int startGap(input int idx);
        if (idx + 1 < rxStart.size()) begin
            return rxStart[idx + 1] - rxStart[idx];
        end
        return -1;
    endfunction

    // Ideal line level o cycles after a write to an empty idle transmitter.
    function automatic logic expectedLine(input logic [7:0] value, input int o);
        if (o < 2)   return 1'b1;
        if (o < 18)  return 1'b0;
        if (o < 146) return value[(o - 18) / CPB];
        return 1'b1;
    endfunction

    // Line decoder: finds each start bit, samples mid-bit and queues the byte and its start cycle.
    initial begin : lineMonitor
        logic [7:0] rxByte;
        int         startAt;
        rxByte  = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.dout === 1'b0) begin
                startAt = cycle;
                repeat (CPB / 2) @(negedge clk);
                checkOutput("startMid", 32'(bus.dout), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rxByte[i] = bus.dout;
                end
                repeat (CPB) @(negedge clk);
                checkOutput("stopMid", 32'(bus.dout), 32'd1);
                rxQueue.push_back(rxByte);
                rxStart.push_back(startAt);
            end
        end
    end

    // Running tally of cycles with overflow high; tests look at differences.
    initial begin : overflowTally
        forever begin
            @(negedge clk);
            if (bus.overflow === 1'b1) overflowCount++;
        end
    end

    // Hard stop in case something wedges the sequence below.
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: observed still running at cycle %0d, expected finish", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin : mainSequence
        int ovfBase;
        int frameBase;
        int activity;

        bus.din_valid = 1'b0;
        bus.din       = 8'h00;
        rst           = 1'b1;

        // Reset state.
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("resetDout", 32'(bus.dout), 32'd1);
        checkOutput("resetFull", 32'(bus.full), 32'd0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetOverflow", 32'(bus.overflow), 32'd0);
        nextCycle();
        rst = 1'b0;

        // Idle with junk on din and no strobe: line must stay high.
        for (int i = 0; i < 5; i++) begin
            bus.din = 8'($urandom);
            @(negedge clk);
            checkOutput("idleDout", 32'(bus.dout), 32'd1);
            checkOutput("idleBusy", 32'(bus.busy), 32'd0);
            nextCycle();
        end

        // Single byte: full cycle-by-cycle waveform of 0xA5 plus busy timing.
        $display("[TB] single byte 0xA5");
        applyStimulus(8'hA5);
        for (int o = 1; o <= 162; o++) begin
            @(negedge clk);
            checkOutput("singleDout", 32'(bus.dout), 32'(expectedLine(8'hA5, o)));
            if (o == 1)   checkOutput("singleBusyStart", 32'(bus.busy), 32'd1);
            if (o == 161) checkOutput("singleBusyLastStop", 32'(bus.busy), 32'd1);
            if (o == 162) checkOutput("singleBusyFall", 32'(bus.busy), 32'd0);
            nextCycle();
        end
        expectRx("singleByte", 8'hA5);

        // Burst of three: contiguous 160-cycle frames.
        $display("[TB] burst 01 02 03");
        frameBase = readIdx;
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        waitIdle("burstDrain", 800);
        expectRx("burstByte0", 8'h01);
        expectRx("burstByte1", 8'h02);
        expectRx("burstByte2", 8'h03);
        checkOutput("burstGap01", 32'(startGap(frameBase)), 32'd160);
        checkOutput("burstGap12", 32'(startGap(frameBase + 1)), 32'd160);

        // Overflow: six back-to-back writes, one in the shifter, four queued, sixth dropped.
        $display("[TB] overflow with six writes");
        ovfBase = overflowCount;
        for (int i = 0; i < 6; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = 8'(8'h10 + i);
            @(negedge clk);
            if (i == 4) checkOutput("fullBeforeFourth", 32'(bus.full), 32'd0);
            if (i == 5) checkOutput("fullAfterFourth", 32'(bus.full), 32'd1);
            nextCycle();
        end
        bus.din_valid = 1'b0;
        @(negedge clk);
        checkOutput("overflowPulse", 32'(bus.overflow), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("overflowPulseEnd", 32'(bus.overflow), 32'd0);
        waitIdle("overflowDrain", 1200);
        checkOutput("overflowPulseCount", 32'(overflowCount - ovfBase), 32'd1);
        for (int i = 0; i < 5; i++) begin
            expectRx("overflowByte", 8'(8'h10 + i));
        end
        checkOutput("overflowByteCount", 32'(rxQueue.size()), 32'(readIdx));

        // Full with a pop on the same edge: the write is still dropped.
        $display("[TB] write while full at stop end");
        for (int i = 0; i < 5; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = 8'(8'h20 + i);
            nextCycle();
        end
        bus.din_valid = 1'b0;
        repeat (156) nextCycle();
        bus.din_valid = 1'b1;
        bus.din       = 8'hEE;
        @(negedge clk);
        checkOutput("fullAtStopEnd", 32'(bus.full), 32'd1);
        checkOutput("lastStopBit", 32'(bus.dout), 32'd1);
        nextCycle();
        bus.din_valid = 1'b0;
        @(negedge clk);
        checkOutput("popOverflow", 32'(bus.overflow), 32'd1);
        checkOutput("popFullDrop", 32'(bus.full), 32'd0);
        checkOutput("popNextStart", 32'(bus.dout), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("popOverflowEnd", 32'(bus.overflow), 32'd0);
        waitIdle("popDrain", 1000);
        for (int i = 0; i < 5; i++) begin
            expectRx("popByte", 8'(8'h20 + i));
        end
        checkOutput("popByteCount", 32'(rxQueue.size()), 32'(readIdx));

        // Reset during data bit 3 with two bytes queued.
        $display("[TB] reset mid-frame");
        applyStimulus(8'h30);
        applyStimulus(8'h31);
        applyStimulus(8'h32);
        repeat (69) nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("preResetBit3", 32'(bus.dout), 32'd0);
        checkOutput("preResetFull", 32'(bus.busy), 32'd1);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postResetDout", 32'(bus.dout), 32'd1);
        checkOutput("postResetBusy", 32'(bus.busy), 32'd0);
        checkOutput("postResetFull", 32'(bus.full), 32'd0);
        activity = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.dout !== 1'b1 || bus.busy !== 1'b0) activity++;
        end
        checkOutput("postResetQuiet", 32'(activity), 32'd0);
        readIdx = rxQueue.size();
        nextCycle();

        // Pointer wrap: twenty paced bytes, none lost, no overflow.
        $display("[TB] pointer wrap with 20 paced bytes");
        ovfBase = overflowCount;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'(i));
            repeat (159) nextCycle();
        end
        waitIdle("wrapDrain", 400);
        checkOutput("wrapOverflow", 32'(overflowCount - ovfBase), 32'd0);
        for (int i = 0; i < 20; i++) begin
            expectRx("wrapByte", 8'(i));
        end
        checkOutput("wrapByteCount", 32'(rxQueue.size()), 32'(readIdx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
